wb_sel_pipe: RTL and testbench

- Parametrised, registered write-back selector for the pipelined miniRV core; successor to the single-cycle combinational write-back mux.
- Selects one of NUM_SRC result sources and applies RV32I load byte/half extraction with sign/zero extension on the memory source.
- Holds the result in a one-entry valid/ready pipeline register that drives the register-file write port, a forwarding tap, and a retired-instruction counter.

---
 rtl/wb_sel_pipe.sv | 86 ++++++++
 tb/tb_wb_sel_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_sel_pipe.sv
// wb_sel_pipe: registered write-back source select with RV32I load extension,
// one-entry valid/ready holding register feeding the RF write port and forwarding tap.
module wb_sel_pipe #(
  parameter int DATA_W   = 32,
  parameter int NUM_SRC  = 4,
  parameter int SEL_W    = 2,
  parameter int LOAD_SRC = 1,
  parameter int RA_W     = 5,
  parameter int CNT_W    = 32
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [NUM_SRC*DATA_W-1:0] in_src,
  input  logic [RA_W-1:0]           in_rd,
  input  logic                      in_we,
  input  logic [2:0]                in_funct3,
  input  logic [1:0]                in_addr_lo,
  input  logic                      flush,
  input  logic                      out_ready,
  output logic                      rf_we,
  output logic [RA_W-1:0]           rf_wR,
  output logic [DATA_W-1:0]         rf_wD,
  output logic                      fwd_valid,
  output logic [RA_W-1:0]           fwd_rd,
  output logic [DATA_W-1:0]         fwd_data,
  output logic [CNT_W-1:0]          retired
);
  logic              valid_q, valid_d, we_q, we_d;
  logic [RA_W-1:0]   rd_q;
  logic [DATA_W-1:0] data_q, data_d, word, load_w;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic              sel_ok, is_load, capture, retire;
  // Out-of-range selects match no source, leaving word=0 and sel_ok=0
  always_comb begin
    word   = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      if (in_sel == SEL_W'(k)) begin
        word   = in_src[k*DATA_W +: DATA_W];
        sel_ok = 1'b1;
      end
  end
  assign byte_v  = word[{in_addr_lo, 3'b000} +: 8];
  assign half_v  = word[{in_addr_lo[1], 4'b0000} +: 16];
  assign is_load = in_sel == SEL_W'(LOAD_SRC);
  assign load_w  = in_funct3 == 3'b000 ? {{(DATA_W-8){byte_v[7]}}, byte_v} :
                   in_funct3 == 3'b100 ? {{(DATA_W-8){1'b0}}, byte_v} :
                   in_funct3 == 3'b001 ? {{(DATA_W-16){half_v[15]}}, half_v} :
                   in_funct3 == 3'b101 ? {{(DATA_W-16){1'b0}}, half_v} : word;
  assign data_d    = is_load ? load_w : word;
  assign we_d      = in_we && sel_ok && (in_rd != '0);
  assign in_ready  = !valid_q || out_ready;
  assign capture   = in_valid && in_ready && !flush;
  assign retire    = valid_q && out_ready && !flush;
  assign valid_d   = !flush && (capture || (valid_q && !out_ready));
  assign retired_d = retired_q + CNT_W'(retire);
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      retired_q <= '0;
    end else begin
      valid_q   <= valid_d;
      retired_q <= retired_d;
      if (capture) begin
        we_q   <= we_d;
        rd_q   <= in_rd;
        data_q <= data_d;
      end
    end
  end
  assign rf_we     = valid_q && we_q && out_ready;
  assign rf_wR     = rd_q;
  assign rf_wD     = data_q;
  assign fwd_valid = valid_q && we_q;
  assign fwd_rd    = rd_q;
  assign fwd_data  = data_q;
  assign retired   = retired_q;
endmodule

// File: tb/tb_wb_sel_pipe.sv
// tb_wb_sel_pipe: vector table plus scoreboard for wb_sel_pipe, with hand-written
// backpressure, flush, out-of-range select and mid-stream reset sequences.
module tb_wb_sel_pipe;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_we = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [1:0]   in_sel = '0, in_addr_lo = '0;
  logic [4:0]   in_rd = '0;
  logic [2:0]   in_funct3 = '0;
  logic [31:0]  srcs [4];
  logic [127:0] in_src;
  logic         in_ready, rf_we, fwd_valid;
  logic [4:0]   rf_wR, fwd_rd;
  logic [31:0]  rf_wD, fwd_data, retired;
  logic         in_ready3, rf_we3, fwd_valid3;
  logic [4:0]   rf_wR3, fwd_rd3;
  logic [31:0]  rf_wD3, fwd_data3, retired3;
  int errors = 0, checks = 0;
  typedef struct { logic [4:0] rd; logic [31:0] d; } exp_t;
  typedef struct { logic [1:0] sel; logic [31:0] w; logic [4:0] rd; logic we;
                   logic [2:0] f3; logic [1:0] lo; logic [31:0] exp_d; logic exp_we; } vec_t;
  exp_t q[$];
  exp_t e;
  vec_t vecs [14];
  assign in_src = {srcs[3], srcs[2], srcs[1], srcs[0]};
  always #5 clk = ~clk;
  wb_sel_pipe u0 (
    .cpu_clk(clk), .cpu_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_src(in_src), .in_rd(in_rd), .in_we(in_we),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .flush(flush), .out_ready(out_ready),
    .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .retired(retired));
  wb_sel_pipe #(.NUM_SRC(3)) u1 (
    .cpu_clk(clk), .cpu_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_sel(in_sel), .in_src(in_src[95:0]), .in_rd(in_rd), .in_we(in_we),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .flush(flush), .out_ready(out_ready),
    .rf_we(rf_we3), .rf_wR(rf_wR3), .rf_wD(rf_wD3), .fwd_valid(fwd_valid3),
    .fwd_rd(fwd_rd3), .fwd_data(fwd_data3), .retired(retired3));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] sel, input logic [31:0] w, input logic [4:0] rd,
                       input logic we, input logic [2:0] f3, input logic [1:0] lo);
    for (int k = 0; k < 4; k++) srcs[k] = 32'hDEAD_0000 | k;
    srcs[sel]  = w;
    in_sel     = sel;
    in_rd      = rd;
    in_we      = we;
    in_funct3  = f3;
    in_addr_lo = lo;
    in_valid   = 1'b1;
  endtask
  // Every forwarded entry that the sink accepts must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && fwd_valid && out_ready) begin
      if (q.size() == 0) chk("sb_unexpected_write", 32'(fwd_rd), 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        chk("sb_rf_we", 32'(rf_we), 32'd1);
        chk("sb_rf_wR", 32'(rf_wR), 32'(e.rd));
        chk("sb_rf_wD", rf_wD, e.d);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int k = 0; k < 4; k++) srcs[k] = '0;
    vecs[0]  = '{2'd0, 32'h0000_000A, 5'd1,  1'b1, 3'b010, 2'd0, 32'h0000_000A, 1'b1};
    vecs[1]  = '{2'd2, 32'h0000_0104, 5'd2,  1'b1, 3'b010, 2'd0, 32'h0000_0104, 1'b1};
    vecs[2]  = '{2'd3, 32'hFFFF_F000, 5'd3,  1'b1, 3'b010, 2'd0, 32'hFFFF_F000, 1'b1};
    vecs[3]  = '{2'd1, 32'h1234_80FF, 5'd5,  1'b1, 3'b000, 2'd1, 32'hFFFF_FF80, 1'b1};
    vecs[4]  = '{2'd1, 32'h8001_7FFE, 5'd6,  1'b1, 3'b101, 2'd2, 32'h0000_8001, 1'b1};
    vecs[5]  = '{2'd1, 32'h8001_7FFE, 5'd7,  1'b1, 3'b001, 2'd0, 32'h0000_7FFE, 1'b1};
    vecs[6]  = '{2'd1, 32'h8001_7FFE, 5'd8,  1'b1, 3'b010, 2'd0, 32'h8001_7FFE, 1'b1};
    vecs[7]  = '{2'd0, 32'h0000_00F0, 5'd9,  1'b1, 3'b000, 2'd1, 32'h0000_00F0, 1'b1};
    vecs[8]  = '{2'd1, 32'h1234_80FF, 5'd10, 1'b1, 3'b100, 2'd0, 32'h0000_00FF, 1'b1};
    vecs[9]  = '{2'd1, 32'h8234_5678, 5'd11, 1'b1, 3'b000, 2'd3, 32'hFFFF_FF82, 1'b1};
    vecs[10] = '{2'd1, 32'h8001_7FFE, 5'd12, 1'b1, 3'b001, 2'd3, 32'hFFFF_8001, 1'b1};
    vecs[11] = '{2'd1, 32'h1234_5678, 5'd13, 1'b1, 3'b011, 2'd1, 32'h1234_5678, 1'b1};
    vecs[12] = '{2'd0, 32'h0000_0055, 5'd0,  1'b1, 3'b010, 2'd0, 32'h0000_0055, 1'b0};
    vecs[13] = '{2'd2, 32'h0000_0077, 5'd14, 1'b0, 3'b010, 2'd0, 32'h0000_0077, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_rf_wR", 32'(rf_wR), 32'd0);
    chk("rst_rf_wD", rf_wD, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].sel, vecs[i].w, vecs[i].rd, vecs[i].we, vecs[i].f3, vecs[i].lo);
      if (vecs[i].exp_we) q.push_back('{vecs[i].rd, vecs[i].exp_d});
      #1;
      chk("vec_in_ready", 32'(in_ready), 32'd1);
      chk("vec_retired", retired, (i == 0) ? 32'd0 : 32'(i - 1));
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #2;
    chk("vec_retired_end", retired, 32'd14);
    chk("vec_idle_fwd", 32'(fwd_valid), 32'd0);
    chk("vec_queue_drained", 32'(q.size()), 32'd0);
    // Backpressure: A held while B waits, then both drain in order
    @(posedge clk); #1 drive(2'd0, 32'h111, 5'd3, 1'b1, 3'b010, 2'd0);
    q.push_back('{5'd3, 32'h111});
    @(posedge clk); #1 out_ready = 1'b0;
    drive(2'd0, 32'h222, 5'd4, 1'b1, 3'b010, 2'd0);
    q.push_back('{5'd4, 32'h222});
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_rf_we", 32'(rf_we), 32'd0);
    chk("bp_fwd_valid", 32'(fwd_valid), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_fwd_rd", 32'(fwd_rd), 32'd3);
      chk("bp_hold_fwd_data", fwd_data, 32'h111);
      chk("bp_hold_retired", retired, 32'd14);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    #1 chk("bp_release_rf_we", 32'(rf_we), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    #1 chk("bp_second_data", fwd_data, 32'h222);
    @(posedge clk); #2;
    chk("bp_done_fwd", 32'(fwd_valid), 32'd0);
    chk("bp_retired", retired, 32'd16);
    chk("bp_queue_drained", 32'(q.size()), 32'd0);
    // Flush on a capture cycle discards the transfer
    @(posedge clk); #1 drive(2'd0, 32'h555, 5'd6, 1'b1, 3'b010, 2'd0);
    flush = 1'b1;
    #1 chk("fl_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("fl_cap_fwd", 32'(fwd_valid), 32'd0);
    chk("fl_cap_rf_we", 32'(rf_we), 32'd0);
    chk("fl_cap_retired", retired, 32'd16);
    // Flush of a held, stalled entry: gone and not retired
    @(posedge clk); #1 drive(2'd0, 32'h666, 5'd7, 1'b1, 3'b010, 2'd0);
    out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b1;
    #1 chk("fl_held_fwd", 32'(fwd_valid), 32'd1);
    @(posedge clk); #1 flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("fl_held_gone", 32'(fwd_valid), 32'd0);
    chk("fl_held_retired", retired, 32'd16);
    // Select beyond NUM_SRC on the three-source instance
    @(posedge clk); #1 drive(2'd3, 32'h3333, 5'd9, 1'b1, 3'b010, 2'd0);
    q.push_back('{5'd9, 32'h3333});
    @(posedge clk); #1 in_valid = 1'b0;
    #1;
    chk("ns3_rf_wD", rf_wD3, 32'd0);
    chk("ns3_rf_we", 32'(rf_we3), 32'd0);
    chk("ns3_fwd_valid", 32'(fwd_valid3), 32'd0);
    chk("ns3_rf_wR", 32'(rf_wR3), 32'd9);
    // Asynchronous reset with an entry held
    @(posedge clk); #1 drive(2'd0, 32'h777, 5'd10, 1'b1, 3'b010, 2'd0);
    out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    #1;
    chk("rm_held", 32'(fwd_valid), 32'd1);
    chk("rm_retired_before", retired, 32'd17);
    rst_n = 1'b0;
    #1;
    chk("rm_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rm_rf_we", 32'(rf_we), 32'd0);
    chk("rm_rf_wR", 32'(rf_wR), 32'd0);
    chk("rm_rf_wD", rf_wD, 32'd0);
    chk("rm_retired", retired, 32'd0);
    chk("rm_retired3", retired3, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2;
    chk("rm_after_fwd", 32'(fwd_valid), 32'd0);
    chk("rm_after_retired", retired, 32'd0);
    chk("final_queue", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
